// File: rtl/alu_share_pkg.sv
// Shared types and constants for the ALU-sharing controller: FSM states, ALU opcodes, default widths.
package alu_share_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_OPCODE_LENGTH = 4;
  localparam int DEF_NUM_REQ       = 2;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_EQ  = 4'b1000;
  localparam logic [3:0] ALU_SLT = 4'b1001;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU shared by the requesters; unknown opcodes yield 0.
module alu
  import alu_share_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int OPCODE_LENGTH = DEF_OPCODE_LENGTH
) (
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic [DATA_WIDTH-1:0]    ALUResult
);

  localparam int SW = $clog2(DATA_WIDTH);

  logic [SW-1:0] w_shamt;
  assign w_shamt = SrcB[SW-1:0];

  always_comb begin
    ALUResult = '0;
    case (Operation)
      OPCODE_LENGTH'(ALU_AND): ALUResult = SrcA & SrcB;
      OPCODE_LENGTH'(ALU_SUB): ALUResult = SrcA - SrcB;
      OPCODE_LENGTH'(ALU_ADD): ALUResult = SrcA + SrcB;
      OPCODE_LENGTH'(ALU_OR):  ALUResult = SrcA | SrcB;
      OPCODE_LENGTH'(ALU_XOR): ALUResult = SrcA ^ SrcB;
      OPCODE_LENGTH'(ALU_SLL): ALUResult = SrcA << w_shamt;
      OPCODE_LENGTH'(ALU_SRL): ALUResult = SrcA >> w_shamt;
      OPCODE_LENGTH'(ALU_SRA): ALUResult = $signed(SrcA) >>> w_shamt;
      OPCODE_LENGTH'(ALU_EQ):  ALUResult = {{(DATA_WIDTH-1){1'b0}}, SrcA == SrcB};
      OPCODE_LENGTH'(ALU_SLT): ALUResult = {{(DATA_WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
      default:                 ALUResult = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl_arbiter.sv
// Grant selection for the ALU sharer. ALU_SHARE_RR_EN selects round-robin; otherwise fixed
// priority with the lowest index winning and no pointer register.
module share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_accept,
  output logic [NUM_REQ-1:0] o_gnt_oh,
  output logic [IW-1:0]      o_gnt_idx,
  output logic               o_any
);

`ifdef ALU_SHARE_RR_EN
  logic [IW-1:0] r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= IW'(NUM_REQ - 1);
    end else if (i_accept) begin
      r_ptr <= o_gnt_idx;
    end
  end

  // Search starts one past the last winner and wraps.
  always_comb begin
    int k;
    k         = 0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(r_ptr) + 1 + i) % NUM_REQ;
      if (!o_any && i_req[k]) begin
        o_any     = 1'b1;
        o_gnt_idx = k[IW-1:0];
      end
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{clk, rst_n, i_accept};

  always_comb begin
    o_gnt_idx = '0;
    o_any     = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_any     = 1'b1;
        o_gnt_idx = IW'(i);
      end
    end
  end
`endif

  assign o_gnt_oh = o_any ? (NUM_REQ'(1) << o_gnt_idx) : '0;

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between NUM_REQ requesters: accept, execute for one cycle, hold result until taken.
// Arbitration mode set by ALU_SHARE_RR_EN inside share_arbiter.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int OPCODE_LENGTH = DEF_OPCODE_LENGTH,
  parameter int NUM_REQ       = DEF_NUM_REQ
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_REQ-1:0]                     ReqValid,
  output logic [NUM_REQ-1:0]                     ReqReady,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     ReqSrcA,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     ReqSrcB,
  input  logic [NUM_REQ-1:0][OPCODE_LENGTH-1:0]  ReqOp,
  output logic [NUM_REQ-1:0]                     RespValid,
  input  logic [NUM_REQ-1:0]                     RespReady,
  output logic [DATA_WIDTH-1:0]                  RespResult,
  output logic [DATA_WIDTH-1:0]                  SrcA,
  output logic [DATA_WIDTH-1:0]                  SrcB,
  output logic [OPCODE_LENGTH-1:0]               Operation,
  input  logic [DATA_WIDTH-1:0]                  ALUResult
);

  localparam int IW = $clog2(NUM_REQ);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [DATA_WIDTH-1:0]    r_src_a;
  logic [DATA_WIDTH-1:0]    r_src_b;
  logic [OPCODE_LENGTH-1:0] r_op;
  logic [DATA_WIDTH-1:0]    r_resp_result;
  logic [NUM_REQ-1:0]       r_resp_valid;
  logic [IW-1:0]            r_gnt_q;

  logic [NUM_REQ-1:0]       w_gnt_oh;
  logic [IW-1:0]            w_gnt_idx;
  logic                     w_any;
  logic                     w_accept;
  logic                     w_capture;
  logic                     w_release;

  share_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (ReqValid),
    .i_accept  (w_accept),
    .o_gnt_oh  (w_gnt_oh),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    ReqReady    = '0;
    case (r_state)
      S_IDLE: begin
        // rst_n gating keeps ReqReady quiet while reset is held, not just after the edge.
        if (w_any && rst_n) begin
          ReqReady    = w_gnt_oh;
          w_accept    = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_capture   = 1'b1;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (RespReady[r_gnt_q]) begin
          w_release   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src_a <= '0;
      r_src_b <= '0;
      r_op    <= '0;
      r_gnt_q <= '0;
    end else if (w_accept) begin
      r_src_a <= ReqSrcA[w_gnt_idx];
      r_src_b <= ReqSrcB[w_gnt_idx];
      r_op    <= ReqOp[w_gnt_idx];
      r_gnt_q <= w_gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_result <= '0;
      r_resp_valid  <= '0;
    end else if (w_capture) begin
      r_resp_result <= ALUResult;
      r_resp_valid  <= NUM_REQ'(1) << r_gnt_q;
    end else if (w_release) begin
      r_resp_valid  <= '0;
    end
  end

  assign SrcA       = r_src_a;
  assign SrcB       = r_src_b;
  assign Operation  = r_op;
  assign RespResult = r_resp_result;
  assign RespValid  = r_resp_valid;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed self-checking bench for alu_share_ctrl driving a real alu instance.
module tb_alu_share_ctrl;
  import alu_share_pkg::*;

  localparam int DW = 32;
  localparam int OL = 4;
  localparam int NR = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NR-1:0]            ReqValid;
  logic [NR-1:0]            ReqReady;
  logic [NR-1:0][DW-1:0]    ReqSrcA;
  logic [NR-1:0][DW-1:0]    ReqSrcB;
  logic [NR-1:0][OL-1:0]    ReqOp;
  logic [NR-1:0]            RespValid;
  logic [NR-1:0]            RespReady;
  logic [DW-1:0]            RespResult;
  logic [DW-1:0]            SrcA;
  logic [DW-1:0]            SrcB;
  logic [OL-1:0]            Operation;
  logic [DW-1:0]            ALUResult;

  int errors = 0;
  int checks = 0;

  alu_share_ctrl #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL), .NUM_REQ(NR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ReqValid   (ReqValid),
    .ReqReady   (ReqReady),
    .ReqSrcA    (ReqSrcA),
    .ReqSrcB    (ReqSrcB),
    .ReqOp      (ReqOp),
    .RespValid  (RespValid),
    .RespReady  (RespReady),
    .RespResult (RespResult),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .Operation  (Operation),
    .ALUResult  (ALUResult)
  );

  alu #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL)) u_alu (
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Operation (Operation),
    .ALUResult (ALUResult)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    ReqValid  = '0;
    ReqSrcA   = '0;
    ReqSrcB   = '0;
    ReqOp     = '0;
    RespReady = '0;
    #2;
    checks++;
    if ({SrcA, SrcB, Operation, RespResult, RespValid, ReqReady} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got SrcA=%h SrcB=%h Op=%h Res=%h RV=%b RR=%b want all 0",
               SrcA, SrcB, Operation, RespResult, RespValid, ReqReady);
    end
    tick();
    rst_n = 1'b1;
    tick();
    // Start an ADD then reset in the middle of EXEC.
    ReqValid   = 2'b01;
    ReqSrcA[0] = 32'd1;
    ReqSrcB[0] = 32'd2;
    ReqOp[0]   = ALU_ADD;
    RespReady  = 2'b11;
    tick();
    checks++;
    if (SrcA !== 32'd1) begin
      errors++;
      $display("FAIL reset_pre_exec SrcA got %h want 00000001", SrcA);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({SrcA, SrcB, Operation, RespResult, RespValid} !== '0) begin
      errors++;
      $display("FAIL reset_mid_exec got SrcA=%h SrcB=%h Op=%h Res=%h RV=%b want all 0",
               SrcA, SrcB, Operation, RespResult, RespValid);
    end
    checks++;
    if (ReqReady !== 2'b00) begin
      errors++;
      $display("FAIL reset_reqready_held got %b want 00", ReqReady);
    end
    ReqValid = '0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (RespValid !== 2'b00) begin
        errors++;
        $display("FAIL reset_no_resp cycle %0d got %b want 00", i, RespValid);
      end
    end
    ReqValid = 2'b01;
    #1;
    checks++;
    if (ReqReady !== 2'b01) begin
      errors++;
      $display("FAIL reset_idle_after got ReqReady %b want 01", ReqReady);
    end
    ReqValid = '0;
    #1;
  endtask

  task automatic test_single();
    RespReady  = 2'b11;
    ReqValid   = 2'b01;
    ReqSrcA[0] = 32'd5;
    ReqSrcB[0] = 32'd7;
    ReqOp[0]   = ALU_ADD;
    #1;
    checks++;
    if (ReqReady !== 2'b01) begin
      errors++;
      $display("FAIL single_accept ReqReady got %b want 01", ReqReady);
    end
    tick();
    ReqValid = '0;
    #1;
    checks++;
    if (SrcA !== 32'd5 || SrcB !== 32'd7 || Operation !== ALU_ADD || ReqReady !== 2'b00) begin
      errors++;
      $display("FAIL single_exec got A=%h B=%h Op=%h RR=%b want 5 7 2 00", SrcA, SrcB, Operation, ReqReady);
    end
    tick();
    checks++;
    if (RespValid !== 2'b01 || RespResult !== 32'd12) begin
      errors++;
      $display("FAIL single_resp got RV=%b Res=%h want 01 0000000c", RespValid, RespResult);
    end
    tick();
    checks++;
    if (RespValid !== 2'b00) begin
      errors++;
      $display("FAIL single_release got RV=%b want 00", RespValid);
    end
  endtask

  task automatic test_backpressure();
    RespReady  = 2'b00;
    ReqValid   = 2'b10;
    ReqSrcA[1] = 32'd3;
    ReqSrcB[1] = 32'd5;
    ReqOp[1]   = ALU_SUB;
    #1;
    checks++;
    if (ReqReady !== 2'b10) begin
      errors++;
      $display("FAIL bp_accept ReqReady got %b want 10", ReqReady);
    end
    tick();
    ReqValid = '0;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (RespValid !== 2'b10 || RespResult !== 32'hFFFFFFFE || ReqReady !== 2'b00) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got RV=%b Res=%h RR=%b want 10 fffffffe 00",
                 i, RespValid, RespResult, ReqReady);
      end
      tick();
    end
    RespReady = 2'b10;
    #1;
    checks++;
    if (RespValid !== 2'b10) begin
      errors++;
      $display("FAIL bp_before_release got RV=%b want 10", RespValid);
    end
    tick();
    checks++;
    if (RespValid !== 2'b00) begin
      errors++;
      $display("FAIL bp_release got RV=%b want 00", RespValid);
    end
    RespReady = 2'b00;
  endtask

  task automatic test_contention();
    logic [NR-1:0] exp_oh;
    logic [DW-1:0] exp_res;
    do_reset();
    RespReady  = 2'b11;
    ReqSrcA[0] = 32'h0000F0F0;
    ReqSrcB[0] = 32'h00000FF0;
    ReqOp[0]   = ALU_XOR;
    ReqSrcA[1] = 32'h00001234;
    ReqSrcB[1] = 32'h00001111;
    ReqOp[1]   = ALU_XOR;
    ReqValid   = 2'b11;
    for (int n = 0; n < 4; n++) begin
`ifdef ALU_SHARE_RR_EN
      exp_oh = (n % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_oh = 2'b01;
`endif
      exp_res = (exp_oh == 2'b01) ? 32'h0000FF00 : 32'h00000325;
      #1;
      checks++;
      if (ReqReady !== exp_oh) begin
        errors++;
        $display("FAIL contention_grant %0d ReqReady got %b want %b", n, ReqReady, exp_oh);
      end
      tick();
      checks++;
      if (ReqReady !== 2'b00) begin
        errors++;
        $display("FAIL contention_exec_busy %0d ReqReady got %b want 00", n, ReqReady);
      end
      tick();
      checks++;
      if (RespValid !== exp_oh || RespResult !== exp_res) begin
        errors++;
        $display("FAIL contention_resp %0d got RV=%b Res=%h want %b %h", n, RespValid, RespResult, exp_oh, exp_res);
      end
      tick();
    end
    ReqValid = '0;
    #1;
  endtask

  task automatic test_stray_ready();
    RespReady  = 2'b10;
    ReqValid   = 2'b01;
    ReqSrcA[0] = 32'hFF00FF00;
    ReqSrcB[0] = 32'h0F0F0F0F;
    ReqOp[0]   = ALU_AND;
    tick();
    ReqValid = '0;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (RespValid !== 2'b01 || RespResult !== 32'h0F000F00) begin
        errors++;
        $display("FAIL stray_hold cycle %0d got RV=%b Res=%h want 01 0f000f00", i, RespValid, RespResult);
      end
      tick();
    end
    RespReady = 2'b01;
    tick();
    checks++;
    if (RespValid !== 2'b00) begin
      errors++;
      $display("FAIL stray_release got RV=%b want 00", RespValid);
    end
  endtask

  task automatic test_ops();
    logic [DW-1:0] ta [5];
    logic [DW-1:0] tb [5];
    logic [OL-1:0] top [5];
    logic [DW-1:0] tr [5];
    ta[0] = 32'h80000000; tb[0] = 32'd4;        top[0] = ALU_SRA; tr[0] = 32'hF8000000;
    ta[1] = 32'hFFFFFFFF; tb[1] = 32'd1;        top[1] = ALU_SLT; tr[1] = 32'd1;
    ta[2] = 32'd5;        tb[2] = 32'd5;        top[2] = ALU_EQ;  tr[2] = 32'd1;
    ta[3] = 32'h12345678; tb[3] = 32'h9ABCDEF0; top[3] = 4'b1111; tr[3] = 32'd0;
    ta[4] = 32'd1;        tb[4] = 32'd31;       top[4] = ALU_SLL; tr[4] = 32'h80000000;
    RespReady = 2'b11;
    for (int i = 0; i < 5; i++) begin
      ReqValid   = 2'b01;
      ReqSrcA[0] = ta[i];
      ReqSrcB[0] = tb[i];
      ReqOp[0]   = top[i];
      tick();
      ReqValid = '0;
      tick();
      checks++;
      if (RespValid !== 2'b01 || RespResult !== tr[i]) begin
        errors++;
        $display("FAIL ops_%0d got RV=%b Res=%h want 01 %h", i, RespValid, RespResult, tr[i]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_contention();
    test_stray_ready();
    test_ops();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
